// File: rtl/riscv_pkg.sv
// Shared types and constants for the ID/EX pipeline slice.
package riscv_pkg;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned REG_IDX_W        = 5;

    // RV32I major opcodes consumed by the decoder feeding this stage
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Decoded control bundle travelling with each instruction
    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic       halt;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 load_use_c
);

    // x0 is never a real producer, so it cannot create a dependency
    always_comb begin
        load_use_c = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble/flush handling and halt drain FSM.
// Build option: define ID_EX_HAZARD_DETECT_EN to enable load-use stall detection.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rd1,
    input  logic [XLEN-1:0]      id_rd2,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [2:0]           id_funct3,
    input  logic [6:0]           id_funct7,
    input  ctrl_t                id_ctrl,
    input  logic                 flush,
    output logic                 stall_o,
    output logic                 ex_valid,
    output ctrl_t                ex_ctrl,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rd1,
    output logic [XLEN-1:0]      ex_rd2,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [2:0]           ex_funct3,
    output logic [6:0]           ex_funct7,
    output logic                 halted_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    halt_state_t      state_q;
    halt_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hazard_c;
    logic             capture_c;
    logic             halt_enter_c;

`ifdef ID_EX_HAZARD_DETECT_EN
    hazard_unit u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use_c  (hazard_c)
    );
`else
    assign hazard_c = 1'b0;
`endif

    // Halt FSM state and drain counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter DRAIN on capturing a valid Halt, count down, then park in HALTED
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (halt_enter_c) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Edge decision: halt activity beats flush, flush beats a load-use stall
    always_comb begin
        capture_c    = 1'b0;
        stall_o      = 1'b0;
        halt_enter_c = 1'b0;
        if (state_q != RUN) begin
            stall_o = 1'b1;
        end else if (flush) begin
            stall_o = 1'b0;
        end else if (hazard_c) begin
            stall_o = 1'b1;
        end else begin
            capture_c    = 1'b1;
            halt_enter_c = id_valid && id_ctrl.halt;
        end
    end

    // Pipeline register; bubbles clear valid and controls but leave data untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_pc     <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_funct3 <= '0;
            ex_funct7 <= '0;
        end else if (capture_c) begin
            ex_valid  <= id_valid;
            ex_ctrl   <= id_valid ? id_ctrl : '0;
            ex_pc     <= id_pc;
            ex_rd1    <= id_rd1;
            ex_rd2    <= id_rd2;
            ex_imm    <= id_imm;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_rd     <= id_rd;
            ex_funct3 <= id_funct3;
            ex_funct7 <= id_funct7;
        end else begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
        end
    end

    // Registered halted flag, set on the edge the FSM parks in HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_o <= 1'b0;
        end else begin
            halted_o <= (state_d == HALTED);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: cycle-level reference model plus directed literal checks.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DRAIN = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    ctrl_t           id_ctrl;
    logic            flush;
    logic            stall_o;
    logic            ex_valid;
    ctrl_t           ex_ctrl;
    logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic            halted_o;

    int n_cmp = 0;
    int n_err = 0;

    ctrl_t c_none, c_add, c_lw, c_halt;

    id_ex_stage #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_ctrl(id_ctrl), .flush(flush),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what EX must hold, and how long ago a Halt reached EX
    logic            m_valid;
    ctrl_t           m_ctrl;
    logic [XLEN-1:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [2:0]      m_f3;
    logic [6:0]      m_f7;
    logic            m_halt_seen;
    int              m_age;

    function automatic logic model_hazard();
`ifdef ID_EX_HAZARD_DETECT_EN
        return m_valid && m_ctrl.mem_read && (m_rd != 5'd0) && id_valid &&
               ((m_rd == id_rs1) || (m_rd == id_rs2));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_stall();
        return m_halt_seen || (model_hazard() && !flush);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_ctrl <= '0; m_pc <= '0; m_rd1 <= '0; m_rd2 <= '0; m_imm <= '0;
            m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_f3 <= '0; m_f7 <= '0;
            m_halt_seen <= 1'b0; m_age <= 0;
        end else if (m_halt_seen) begin
            m_valid <= 1'b0; m_ctrl <= '0;
            if (m_age < 1000) m_age <= m_age + 1;
        end else if (flush || model_hazard()) begin
            m_valid <= 1'b0; m_ctrl <= '0;
        end else begin
            m_valid <= id_valid;
            m_ctrl  <= id_valid ? id_ctrl : '0;
            m_pc <= id_pc; m_rd1 <= id_rd1; m_rd2 <= id_rd2; m_imm <= id_imm;
            m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd; m_f3 <= id_funct3; m_f7 <= id_funct7;
            if (id_valid && id_ctrl.halt) begin
                m_halt_seen <= 1'b1;
                m_age       <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 || rst_n === 1'b0) begin
            check("cyc_ex_valid", 64'(ex_valid), 64'(m_valid));
            check("cyc_ex_ctrl",  64'(ex_ctrl),  64'(m_ctrl));
            check("cyc_ex_pc",    64'(ex_pc),    64'(m_pc));
            check("cyc_ex_rd1",   64'(ex_rd1),   64'(m_rd1));
            check("cyc_ex_rd2",   64'(ex_rd2),   64'(m_rd2));
            check("cyc_ex_imm",   64'(ex_imm),   64'(m_imm));
            check("cyc_ex_rs",    64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
            check("cyc_ex_funct", 64'({ex_funct3, ex_funct7}), 64'({m_f3, m_f7}));
            check("cyc_stall",    64'(stall_o),  64'(model_stall()));
            check("cyc_halted",   64'(halted_o), 64'(m_halt_seen && (m_age >= int'(DRAIN))));
        end
    end

    task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input ctrl_t c,
                          input logic fl);
        id_valid  = v;
        id_pc     = pc;
        id_rd1    = pc ^ 32'hA5A5_0000;
        id_rd2    = pc + 32'h0000_0100;
        id_imm    = ~pc;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_funct3 = pc[2:0];
        id_funct7 = {2'b00, rd};
        id_ctrl   = c;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        c_none = '0;
        c_add  = '0; c_add.reg_write = 1'b1; c_add.alu_op = 2'b10;
        c_lw   = '0; c_lw.alu_src = 1'b1; c_lw.mem_to_reg = 1'b1; c_lw.reg_write = 1'b1;
        c_lw.mem_read = 1'b1;
        c_halt = '0; c_halt.halt = 1'b1;

        rst_n = 1'b1;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, c_none, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid",  64'(ex_valid), 64'd0);
        check("rst_stall",  64'(stall_o),  64'd0);
        check("rst_halted", 64'(halted_o), 64'd0);
        check("rst_pc",     64'(ex_pc),    64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Plain ALU instruction flows through in one cycle
        set_id(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, c_add, 1'b0);
        step();
        check("add_valid",    64'(ex_valid),          64'd1);
        check("add_pc",       64'(ex_pc),             64'h10);
        check("add_regwrite", 64'(ex_ctrl.reg_write), 64'd1);
        check("add_stall",    64'(stall_o),           64'd0);

        // Load followed by a consumer of its destination
        set_id(1'b1, 32'h14, 5'd7, 5'd8, 5'd5, c_lw, 1'b0);
        step();
        set_id(1'b1, 32'h18, 5'd5, 5'd9, 5'd10, c_add, 1'b0);
        #1;
`ifdef ID_EX_HAZARD_DETECT_EN
        check("lu_stall", 64'(stall_o), 64'd1);
        step();
        check("lu_bubble",  64'(ex_valid), 64'd0);
        check("lu_release", 64'(stall_o),  64'd0);
        step();
`else
        check("lu_nostall", 64'(stall_o), 64'd0);
        step();
`endif
        check("lu_dep_valid", 64'(ex_valid), 64'd1);
        check("lu_dep_pc",    64'(ex_pc),    64'h18);

        // A load to x0 never stalls a reader of x0
        set_id(1'b1, 32'h1c, 5'd1, 5'd1, 5'd0, c_lw, 1'b0);
        step();
        set_id(1'b1, 32'h20, 5'd0, 5'd0, 5'd4, c_add, 1'b0);
        #1;
        check("x0_stall", 64'(stall_o), 64'd0);
        step();
        check("x0_pc", 64'(ex_pc), 64'h20);

        // Flush coincident with a load-use: flush wins, consumer dropped
        set_id(1'b1, 32'h24, 5'd2, 5'd3, 5'd6, c_lw, 1'b0);
        step();
        set_id(1'b1, 32'h28, 5'd6, 5'd6, 5'd7, c_add, 1'b1);
        #1;
        check("fh_stall", 64'(stall_o), 64'd0);
        step();
        check("fh_bubble", 64'(ex_valid), 64'd0);
        check("fh_ctrl",   64'(ex_ctrl),  64'd0);
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, c_none, 1'b0);
        step();
        check("fh_dropped", 64'(ex_valid), 64'd0);

        // Flushed Halt is discarded
        set_id(1'b1, 32'h2c, 5'd0, 5'd0, 5'd0, c_halt, 1'b1);
        step();
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, c_none, 1'b0);
        repeat (4) step();
        check("fhalt_halted", 64'(halted_o), 64'd0);
        check("fhalt_stall",  64'(stall_o),  64'd0);

        // Mixed traffic with frequent register reuse and occasional flushes
        for (int i = 0; i < 24; i++) begin
            set_id(1'b1, 32'h100 + 32'(i * 4), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? c_lw : c_add,
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0) id_valid = 1'b0;
            step();
        end

        // Reset in the middle of a drain abandons the halt
        set_id(1'b1, 32'h40, 5'd0, 5'd0, 5'd0, c_halt, 1'b0);
        step();
        check("drain_stall", 64'(stall_o), 64'd1);
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, c_none, 1'b0);
        step();
        #1 rst_n = 1'b0;
        #1;
        check("mid_valid",  64'(ex_valid), 64'd0);
        check("mid_ctrl",   64'(ex_ctrl),  64'd0);
        check("mid_pc",     64'(ex_pc),    64'd0);
        check("mid_stall",  64'(stall_o),  64'd0);
        check("mid_halted", 64'(halted_o), 64'd0);
        #1 rst_n = 1'b1;
        step();
        check("post_stall", 64'(stall_o), 64'd0);

        // Full halt: halted three edges after the Halt reaches EX, sticky until reset
        set_id(1'b1, 32'h50, 5'd0, 5'd0, 5'd0, c_halt, 1'b0);
        step();
        check("halt_ex_valid", 64'(ex_valid),     64'd1);
        check("halt_ex_bit",   64'(ex_ctrl.halt), 64'd1);
        check("halt_stall_n1", 64'(stall_o),      64'd1);
        check("halt_done_n0",  64'(halted_o),     64'd0);
        set_id(1'b1, 32'h54, 5'd1, 5'd2, 5'd3, c_add, 1'b1);
        step();
        check("halt_done_n1", 64'(halted_o), 64'd0);
        check("halt_bubble",  64'(ex_valid), 64'd0);
        step();
        check("halt_done_n2", 64'(halted_o), 64'd0);
        step();
        check("halt_done_n3", 64'(halted_o), 64'd1);
        set_id(1'b1, 32'h58, 5'd1, 5'd2, 5'd3, c_add, 1'b0);
        repeat (5) step();
        check("halt_sticky", 64'(halted_o), 64'd1);
        check("halt_stall",  64'(stall_o),  64'd1);
        check("halt_idle",   64'(ex_valid), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("halt_reset", 64'(halted_o), 64'd0);
        #1 rst_n = 1'b1;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, c_none, 1'b0);
        step();
        check("halt_rerun", 64'(stall_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
